// File: rtl/mux21_rr_arbiter.sv
// mux21_rr_arbiter
//   Round-robin arbiter/sequencer in front of a registered 2:1 multiplexer.
//   Two valid/ready sources compete for one registered output stage. A source
//   keeps the grant while it has data. It hands over early when it goes idle.
//   It also hands over once it has had MAX_BURST accepts while the other
//   source is waiting.
//
//   Ports
//     clk        clock, all state updates on posedge
//     reset      synchronous, active-high reset
//     valid0     source 0 offers data_in0
//     data_in0   source 0 word
//     ready0     source 0 word accepted this cycle if valid0
//     valid1     source 1 offers data_in1
//     data_in1   source 1 word
//     ready1     source 1 word accepted this cycle if valid1
//     data_out   registered muxed word
//     valid_out  data_out holds an unconsumed word
//     ready_out  downstream consumes data_out this cycle if valid_out
//     selector   current mux select (0 = source 0, 1 = source 1)
module mux21_rr_arbiter #(
  parameter int DATA_WIDTH = 2,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid0,
  input  logic [DATA_WIDTH-1:0] data_in0,
  output logic                  ready0,
  input  logic                  valid1,
  input  logic [DATA_WIDTH-1:0] data_in1,
  output logic                  ready1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic                  selector
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW:0] MAX_CNT = (CW + 1)'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [CW-1:0]         burst_cnt_q, burst_cnt_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;

  logic                  out_free;
  logic                  valid_sel;
  logic                  accept;
  logic [DATA_WIDTH-1:0] data_sel;
  // One bit wider than the counter so the increment cannot wrap before saturation.
  logic [CW:0]           cnt_nxt;
  logic                  burst_done;
  logic [CW-1:0]         cnt_sat;

  assign out_free  = !valid_out_q || ready_out;
  assign ready0    = (state_q == GNT0) && out_free;
  assign ready1    = (state_q == GNT1) && out_free;
  assign selector  = (state_q == GNT1);
  assign valid_sel = selector ? valid1 : valid0;
  assign data_sel  = selector ? data_in1 : data_in0;
  assign accept    = valid_sel && (ready0 || ready1);

  assign cnt_nxt    = {1'b0, burst_cnt_q} + {{CW{1'b0}}, accept};
  assign burst_done = (cnt_nxt >= MAX_CNT);
  assign cnt_sat    = burst_done ? MAX_CNT[CW-1:0] : cnt_nxt[CW-1:0];

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;

  // Output stage: a new word may be loaded in the same cycle the old one leaves.
  always_comb begin
    data_out_d  = data_out_q;
    valid_out_d = valid_out_q;
    if (accept) begin
      data_out_d  = data_sel;
      valid_out_d = 1'b1;
    end else if (ready_out) begin
      valid_out_d = 1'b0;
    end
  end

  // Grant sequencing. Decisions use the count including this cycle's accept,
  // so the switch happens in the same cycle as the capping accept.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    unique case (state_q)
      IDLE: begin
        burst_cnt_d = '0;
        if (valid0 && valid1) state_d = last_grant_q ? GNT0 : GNT1;
        else if (valid0)      state_d = GNT0;
        else if (valid1)      state_d = GNT1;
      end
      GNT0: begin
        if (valid1 && (!valid0 || burst_done)) begin
          state_d      = GNT1;
          last_grant_d = 1'b1;
          burst_cnt_d  = '0;
        end else if (!valid0 && !valid1) begin
          state_d     = IDLE;
          burst_cnt_d = '0;
        end else begin
          burst_cnt_d = cnt_sat;
        end
      end
      GNT1: begin
        if (valid0 && (!valid1 || burst_done)) begin
          state_d      = GNT0;
          last_grant_d = 1'b0;
          burst_cnt_d  = '0;
        end else if (!valid0 && !valid1) begin
          state_d     = IDLE;
          burst_cnt_d = '0;
        end else begin
          burst_cnt_d = cnt_sat;
        end
      end
      default: begin
        state_d     = IDLE;
        burst_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      burst_cnt_q  <= '0;
      data_out_q   <= '0;
      valid_out_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      data_out_q   <= data_out_d;
      valid_out_q  <= valid_out_d;
    end
  end

endmodule

// File: tb/tb_mux21_rr_arbiter.sv
// Bench for mux21_rr_arbiter: two instances (MAX_BURST 4 and 1) share one
// stimulus stream and are each checked against a grant/ownership model, an
// accept-order scoreboard and a burst-cap fairness bound.
module tb_mux21_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset, valid0, valid1, ready_out;
  logic [1:0] data_in0, data_in1;
  logic [1:0] r0, r1, vo, sel;
  logic [1:0] dout_a, dout_b;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state per instance: owner -1 = nobody, else source index.
  int mb     [2] = '{4, 1};
  int m_own  [2];
  int m_cnt  [2];
  int m_last [2];
  int m_vout [2];
  int m_dout [2];
  int run    [2];
  int q0[$];
  int q1[$];

  always #5 clk = ~clk;

  mux21_rr_arbiter #(.DATA_WIDTH(2), .MAX_BURST(4)) dut_a (
    .clk(clk), .reset(reset),
    .valid0(valid0), .data_in0(data_in0), .ready0(r0[0]),
    .valid1(valid1), .data_in1(data_in1), .ready1(r1[0]),
    .data_out(dout_a), .valid_out(vo[0]), .ready_out(ready_out),
    .selector(sel[0])
  );

  mux21_rr_arbiter #(.DATA_WIDTH(2), .MAX_BURST(1)) dut_b (
    .clk(clk), .reset(reset),
    .valid0(valid0), .data_in0(data_in0), .ready0(r0[1]),
    .valid1(valid1), .data_in1(data_in1), .ready1(r1[1]),
    .data_out(dout_b), .valid_out(vo[1]), .ready_out(ready_out),
    .selector(sel[1])
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Evaluate one cycle for instance k at the negedge, then advance the model.
  task automatic model_cycle(input int k);
    int obs_d, acc, word, free, i, j, vi, vj, cn, v0, v1, popped;
    obs_d = (k == 0) ? int'(dout_a) : int'(dout_b);
    v0 = int'(valid0);
    v1 = int'(valid1);
    free = (m_vout[k] == 0 || ready_out) ? 1 : 0;
    check($sformatf("ready0[%0d]", k), int'(r0[k]), (m_own[k] == 0 && free == 1) ? 1 : 0);
    check($sformatf("ready1[%0d]", k), int'(r1[k]), (m_own[k] == 1 && free == 1) ? 1 : 0);
    check($sformatf("selector[%0d]", k), int'(sel[k]), (m_own[k] == 1) ? 1 : 0);
    check($sformatf("valid_out[%0d]", k), int'(vo[k]), m_vout[k]);
    check($sformatf("data_out[%0d]", k), obs_d, m_dout[k]);

    if (reset) begin
      m_own[k] = -1; m_cnt[k] = 0; m_last[k] = 1; m_vout[k] = 0; m_dout[k] = 0;
      run[k] = 0;
      if (k == 0) q0.delete(); else q1.delete();
      return;
    end

    // Scoreboard: every consumed word must be the oldest accepted one.
    if (vo[k] && ready_out) begin
      if (k == 0) begin
        if (q0.size() == 0) popped = -1; else popped = q0.pop_front();
      end else begin
        if (q1.size() == 0) popped = -1; else popped = q1.pop_front();
      end
      check($sformatf("order[%0d]", k), obs_d, popped);
    end

    acc = ((m_own[k] == 0 && v0 == 1) || (m_own[k] == 1 && v1 == 1)) && free == 1 ? 1 : 0;
    word = (m_own[k] == 1) ? int'(data_in1) : int'(data_in0);
    if (acc == 1) begin
      m_vout[k] = 1;
      m_dout[k] = word;
      if (k == 0) q0.push_back(word); else q1.push_back(word);
    end else if (ready_out) begin
      m_vout[k] = 0;
    end

    // Fairness: accepts to one source while the other waits never exceed MAX_BURST.
    if (m_own[k] >= 0) begin
      vj = (m_own[k] == 0) ? v1 : v0;
      if (vj == 0) run[k] = 0;
      else if (acc == 1) begin
        run[k]++;
        check($sformatf("burst_cap[%0d]", k), (run[k] <= mb[k]) ? 1 : 0, 1);
      end
    end

    if (m_own[k] < 0) begin
      if (v0 == 1 && v1 == 1) m_own[k] = (m_last[k] == 1) ? 0 : 1;
      else if (v0 == 1) m_own[k] = 0;
      else if (v1 == 1) m_own[k] = 1;
      m_cnt[k] = 0;
    end else begin
      i  = m_own[k];
      j  = 1 - i;
      vi = (i == 0) ? v0 : v1;
      vj = (j == 0) ? v0 : v1;
      cn = m_cnt[k] + acc;
      if (vj == 1 && (vi == 0 || cn >= mb[k])) begin
        m_own[k] = j; m_last[k] = j; m_cnt[k] = 0; run[k] = 0;
      end else if (vi == 0 && vj == 0) begin
        m_own[k] = -1; m_cnt[k] = 0; run[k] = 0;
      end else begin
        m_cnt[k] = (cn > mb[k]) ? mb[k] : cn;
      end
    end
  endtask

  // Inputs applied just after a posedge; checks happen at the following negedge.
  task automatic step(input logic rst, input logic v0, input logic [1:0] x0,
                      input logic v1, input logic [1:0] x1, input logic ro);
    reset = rst; valid0 = v0; data_in0 = x0; valid1 = v1; data_in1 = x1; ready_out = ro;
    @(negedge clk);
    model_cycle(0);
    model_cycle(1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] t1_exp [3];
    logic [1:0] w0, w1;
    int         idx;
    logic       nv0, nv1;
    t1_exp[0] = 2'b01; t1_exp[1] = 2'b10; t1_exp[2] = 2'b11;
    reset = 1'b1; valid0 = 1'b0; valid1 = 1'b0; ready_out = 1'b0;
    data_in0 = '0; data_in1 = '0;
    for (int k = 0; k < 2; k++) begin
      m_own[k] = -1; m_cnt[k] = 0; m_last[k] = 1; m_vout[k] = 0; m_dout[k] = 0; run[k] = 0;
    end
    @(posedge clk); #1;
    step(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
    step(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
    check("rst_valid_out", int'(vo[0]), 0);
    check("rst_data_out", int'(dout_a), 0);
    check("rst_selector", int'(sel[0]), 0);

    // Single source: words held until accepted, appearing back to back.
    idx = 0;
    step(1'b0, 1'b1, t1_exp[0], 1'b0, 2'b00, 1'b1);
    check("t1_grant", int'(r0[0]), 1);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b1, t1_exp[c], 1'b0, 2'b00, 1'b1);
      check("t1_data", int'(dout_a), int'(t1_exp[c]));
      check("t1_ready1", int'(r1[0]), 0);
    end
    step(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
    step(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1);

    // Tie from IDLE, then backpressure during a src1 burst.
    step(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
    for (int c = 0; c < 14; c++)
      step(1'b0, 1'b1, 2'(c), 1'b1, 2'(c + 2), (c >= 6 && c < 9) ? 1'b0 : 1'b1);

    // Early yield: src0 drops after two accepts while src1 waits.
    step(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
    step(1'b0, 1'b1, 2'b01, 1'b1, 2'b10, 1'b1);
    step(1'b0, 1'b1, 2'b01, 1'b1, 2'b10, 1'b1);
    step(1'b0, 1'b1, 2'b11, 1'b1, 2'b10, 1'b1);
    step(1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 1'b1);
    check("t4_sel", int'(sel[0]), 1);

    // Reset in the middle of a src1 burst with a word in flight.
    step(1'b0, 1'b0, 2'b00, 1'b1, 2'b11, 1'b1);
    step(1'b1, 1'b1, 2'b01, 1'b1, 2'b11, 1'b1);
    check("t5_valid_out", int'(vo[0]), 0);
    check("t5_data_out", int'(dout_a), 0);
    step(1'b0, 1'b1, 2'b01, 1'b1, 2'b10, 1'b1);
    step(1'b0, 1'b1, 2'b01, 1'b1, 2'b10, 1'b1);
    check("t5_src0_first", int'(sel[0]), 0);

    // Random traffic; valids mostly persist so bursts and waits occur.
    nv0 = 1'b0; nv1 = 1'b0; w0 = '0; w1 = '0;
    for (int c = 0; c < 1000; c++) begin
      if ($urandom_range(0, 3) == 0) nv0 = ~nv0;
      if ($urandom_range(0, 3) == 0) nv1 = ~nv1;
      if ($urandom_range(0, 1) == 0) w0 = 2'($urandom);
      if ($urandom_range(0, 1) == 0) w1 = 2'($urandom);
      step(1'b0, nv0, w0, nv1, w1, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
